// File: rtl/mem_read_port_if.sv
// Memory read bus between mem_read_port (master) and data memory (slave).
// Mem_RData is valid in the same cycle Mem_Ack is high.
interface mem_read_port_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          Mem_Req;
   logic [AW-1:0] Mem_Addr;
   logic          Mem_Ack;
   logic [DW-1:0] Mem_RData;

   modport master (output Mem_Req, output Mem_Addr, input Mem_Ack, input Mem_RData);
   modport slave  (input Mem_Req, input Mem_Addr, output Mem_Ack, output Mem_RData);
endinterface

// File: rtl/mem_read_port.sv
// Read-side bus master: one-shot read command -> req/ack with data memory -> held MDR word.
// Optional REQ timeout is built when MEM_READ_TIMEOUT_EN is defined.
module mem_read_port #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Read,
   input  logic [AW-1:0] Addr,
   output logic [DW-1:0] Data_out,
   output logic          Busy,
   output logic          Done,
   output logic          Err,
   mem_read_port_if.master mem
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t state;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_read_port: TIMEOUT must be >= 1");
   end

`ifdef MEM_READ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
`else
   assign Err = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state        <= IDLE;
         Data_out     <= '0;
         mem.Mem_Addr <= '0;
         mem.Mem_Req  <= 1'b0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
`ifdef MEM_READ_TIMEOUT_EN
         Err          <= 1'b0;
         cnt          <= '0;
`endif
      end else begin
         Done <= 1'b0;
`ifdef MEM_READ_TIMEOUT_EN
         Err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (Read) begin
                  mem.Mem_Addr <= Addr;
                  mem.Mem_Req  <= 1'b1;
                  Busy         <= 1'b1;
                  state        <= REQ;
`ifdef MEM_READ_TIMEOUT_EN
                  cnt          <= '0;
`endif
               end
            end
            REQ: begin
               // Ack wins over an expiring count on the same edge.
               if (mem.Mem_Ack) begin
                  Data_out    <= mem.Mem_RData;
                  mem.Mem_Req <= 1'b0;
                  Done        <= 1'b1;
                  state       <= DONE;
               end
`ifdef MEM_READ_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT - 1)) begin
                  mem.Mem_Req <= 1'b0;
                  Done        <= 1'b1;
                  Err         <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_read_port.md
Name: mem_read_port

Overview:
- Read-side bus master for the multicycle datapath.
- Accepts a single-cycle read command from the control FSM, then runs a req/ack handshake with data memory.
- Captures the returned word into a held data register, which acts as the MDR read path.
- Signals completion with a one-cycle Done pulse. It is the consumer counterpart of the write-enabled storage registers.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
TIMEOUT, 15, max cycles Mem_Req may stay high without Mem_Ack (used only with the optional feature); must be >= 1

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  asynchronous, active-low reset
Read  input  1  read command from control FSM; sampled only in IDLE
Addr  input  AW  read address; sampled with Read
Data_out  output  DW  last successfully read word; held between reads
Busy  output  1  high while a read is in progress (REQ or DONE state)
Done  output  1  one-cycle pulse when a read finishes
Err  output  1  one-cycle pulse coincident with Done when the read timed out
Mem_Req  output  1  request to memory
Mem_Addr  output  AW  registered address presented to memory
Mem_Ack  input  1  memory acknowledge; Mem_RData valid in the same cycle
Mem_RData  input  DW  memory read data

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low.
- While Reset = 0:
  - state = IDLE
  - Data_out = 0, Mem_Addr = 0
  - Mem_Req = 0, Busy = 0, Done = 0, Err = 0
  - timeout counter = 0
- Reset mid-transaction: the read is aborted, Mem_Req drops immediately (asynchronously), and Data_out returns to 0. No Done is issued.
- All outputs are registered; no combinational input-to-output paths.
- State IDLE:
  - Read = 1 at a posedge: Mem_Addr <= Addr, Mem_Req <= 1, Busy <= 1, go to REQ.
  - Read = 0: stay in IDLE.
  - Mem_Ack in IDLE is ignored.
- State REQ:
  - Mem_Req and Mem_Addr are held stable.
  - Mem_Ack = 1 at a posedge: Data_out <= Mem_RData, Mem_Req <= 0, Done <= 1, go to DONE.
  - Otherwise stay in REQ; Read is ignored.
- State DONE (exactly one cycle):
  - Done = 1, Busy = 1, Mem_Req = 0.
  - On the next posedge: Done <= 0, Busy <= 0, go to IDLE.
  - Read asserted during DONE is ignored.
- Latency:
  - Read sampled at edge 0 → Mem_Req high after edge 0.
  - Mem_Ack sampled at edge k (k >= 1) → Done and new Data_out visible after edge k.
  - Minimum 3 cycles from one accepted Read to the next accepted Read.
- Data_out changes only on a successful ack capture (or on reset). It is never modified by a timeout.
- Mem_Ack that stays high across the DONE cycle must not cause a second capture.

Optional Feature:
- Macro: MEM_READ_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to REQ and increments each REQ cycle without Mem_Ack.
  - If the counter reaches TIMEOUT with Mem_Ack = 0 at that posedge: Mem_Req <= 0, Done <= 1, Err <= 1, go to DONE.
  - Data_out is unchanged on a timeout.
  - Mem_Ack arriving on the same edge the count would expire takes priority: normal capture, Err = 0.
- When not defined:
  - No counter is built, and REQ waits indefinitely.
  - Err is tied to 0.

Test Plan:
- Reset behaviour: assert Reset = 0 with random inputs → all outputs 0. Release Reset, hold Read = 0 for 5 cycles → outputs remain 0.
- Basic read: Read = 1, Addr = 0x0000_0040 for one cycle; memory acks 2 cycles after Mem_Req with 0xDEAD_BEEF.
  - Mem_Addr = 0x40 during REQ.
  - Done pulses exactly one cycle.
  - Data_out = 0xDEAD_BEEF, held until the next read.
  - Busy is high for 4 cycles.
- Ignored inputs:
  - Mem_Ack = 1 while in IDLE → no Done, Data_out unchanged.
  - Read = 1 held during REQ and DONE → exactly one Mem_Req, one Done.
  - Second Read accepted only in IDLE.
- Back-to-back reads: Addr 0x10 then 0x14, each acked on the first REQ cycle with 0x1111_1111 then 0x2222_2222 → Read period of 3 cycles. Data_out sequence 0x1111_1111, then 0x2222_2222.
- Async abort: drive Reset low mid-cycle while in REQ → Mem_Req falls before the next edge. After release, a new Read to 0x80 completes normally.
- Timeout (MEM_READ_TIMEOUT_EN, TIMEOUT = 4):
  - No Mem_Ack → Mem_Req high 4 cycles, then Done = Err = 1 for one cycle; Data_out keeps its previous value 0x2222_2222.
  - Repeat with ack on the 4th REQ cycle → capture, Err = 0.
